// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing generator.
package vga_timing_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Largest axis total an 11-bit coordinate can represent.
  localparam int MAX_TOTAL = 2048;

  function automatic int axis_total(input int active_len, input int front_len,
                                    input int sync_len, input int back_len);
    return active_len + front_len + sync_len + back_len;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to the renderer/display-output blocks.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t pixelx;
  coord_t pixely;
  logic   hsync;
  logic   vsync;
  logic   de;
  logic   line_start;
  logic   frame_start;

  modport master (
    output pixelx, pixely, hsync, vsync, de, line_start, frame_start
  );

  modport slave (
    input pixelx, pixely, hsync, vsync, de, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus its ACTIVE/FRONT/SYNC/BACK phase, both
// registered together so the phase never has to be decoded from the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  output coord_t count,
  output phase_t phase,
  output logic   wrap
);

  localparam int     TOTAL    = axis_total(ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);
  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t FRONT_AT = coord_t'(ACTIVE_LEN);
  localparam coord_t SYNC_AT  = coord_t'(ACTIVE_LEN + FRONT_LEN);
  localparam coord_t BACK_AT  = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1 ||
      TOTAL > MAX_TOTAL) begin : g_bad_params
    $error("vga_axis_counter: every length must be >= 1 and the total <= 2048");
  end

  coord_t count_nxt;
  phase_t phase_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      phase <= ACTIVE;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    wrap      = advance && (count == LAST);
    count_nxt = count;
    phase_nxt = phase;
    if (advance) begin
      count_nxt = wrap ? '0 : count + coord_t'(1);
      case (phase)
        ACTIVE:  if (count_nxt == FRONT_AT) phase_nxt = FRONT;
        FRONT:   if (count_nxt == SYNC_AT)  phase_nxt = SYNC;
        SYNC:    if (count_nxt == BACK_AT)  phase_nxt = BACK;
        BACK:    if (wrap)                  phase_nxt = ACTIVE;
        default:                            phase_nxt = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running H/V counters followed by one output
// register stage that presents coordinates, syncs, de and strobes mutually aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  vga_timing_gen_if.master        vga
);

  localparam coord_t H_LAST = coord_t'(axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK) - 1);
  localparam coord_t V_LAST = coord_t'(axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK) - 1);

  coord_t h_count, v_count;
  phase_t h_phase, v_phase;
  logic   h_wrap,  v_wrap;

  // Stage p0: counters sit one position ahead of the outputs and reset to (0,0),
  // so the first edge after reset presents (0,0) with both strobes.
  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  // A wrap this cycle means the counters now hold column 0 (and row 0 for a frame wrap).
  logic line_head, frame_head;

  coord_t pixelx_p1, pixely_p1;
  logic   hsync_p1, vsync_p1, de_p1, line_start_p1, frame_start_p1;

  // Stage p1: output registers, reset to the last position of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_head      <= 1'b1;
      frame_head     <= 1'b1;
      pixelx_p1      <= H_LAST;
      pixely_p1      <= V_LAST;
      hsync_p1       <= ~HSYNC_POL;
      vsync_p1       <= ~VSYNC_POL;
      de_p1          <= 1'b0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      line_head      <= h_wrap;
      frame_head     <= v_wrap;
      pixelx_p1      <= h_count;
      pixely_p1      <= v_count;
      hsync_p1       <= (h_phase == SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_p1       <= (v_phase == SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de_p1          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      line_start_p1  <= line_head;
      frame_start_p1 <= frame_head;
    end
  end

  assign vga.pixelx      = pixelx_p1;
  assign vga.pixely      = pixely_p1;
  assign vga.hsync       = hsync_p1;
  assign vga.vsync       = vsync_p1;
  assign vga.de          = de_p1;
  assign vga.line_start  = line_start_p1;
  assign vga.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus a tiny 14x7 raster.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  always #5 clk = ~clk;

  vga_timing_gen_if vd ();
  vga_timing_gen_if vs ();

  vga_timing_gen dut (
    .clk (clk),
    .rst (rst),
    .vga (vd)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .vga (vs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int ex, ey, ex_s, ey_s;
  int hs_low, de_hi, ls_cnt;
  int s_hs_low, s_vs_low, s_de_hi, s_ls_cnt, s_fs_cnt, s_corner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check the default DUT against the expected position (ex, ey), then advance one clk.
  task automatic step_d();
    chk("d_pixelx", 32'(vd.pixelx), ex);
    chk("d_pixely", 32'(vd.pixely), ey);
    chk("d_hsync",  32'(vd.hsync), (ex >= 656 && ex <= 751) ? 0 : 1);
    chk("d_vsync",  32'(vd.vsync), (ey >= 490 && ey <= 491) ? 0 : 1);
    chk("d_de",     32'(vd.de), (ex < 640 && ey < 480) ? 1 : 0);
    chk("d_line_start",  32'(vd.line_start), (ex == 0) ? 1 : 0);
    chk("d_frame_start", 32'(vd.frame_start), (ex == 0 && ey == 0) ? 1 : 0);
    if (vd.hsync === 1'b0) hs_low++;
    if (vd.de === 1'b1) de_hi++;
    if (vd.line_start === 1'b1) ls_cnt++;
    ex++;
    if (ex == 800) begin
      ex = 0;
      ey++;
      if (ey == 525) ey = 0;
    end
    @(negedge clk);
  endtask

  // Same for the 14x7 instance: hsync at x 10..11, vsync on line 5, active 8x4.
  task automatic step_s();
    chk("s_pixelx", 32'(vs.pixelx), ex_s);
    chk("s_pixely", 32'(vs.pixely), ey_s);
    chk("s_hsync",  32'(vs.hsync), (ex_s >= 10 && ex_s <= 11) ? 0 : 1);
    chk("s_vsync",  32'(vs.vsync), (ey_s == 5) ? 0 : 1);
    chk("s_de",     32'(vs.de), (ex_s < 8 && ey_s < 4) ? 1 : 0);
    chk("s_line_start",  32'(vs.line_start), (ex_s == 0) ? 1 : 0);
    chk("s_frame_start", 32'(vs.frame_start), (ex_s == 0 && ey_s == 0) ? 1 : 0);
    if (vs.hsync === 1'b0) s_hs_low++;
    if (vs.vsync === 1'b0) s_vs_low++;
    if (vs.de === 1'b1) s_de_hi++;
    if (vs.line_start === 1'b1) s_ls_cnt++;
    if (vs.frame_start === 1'b1) s_fs_cnt++;
    if (vs.pixelx === 11'd7 && vs.pixely === 11'd3) s_corner++;
    ex_s++;
    if (ex_s == 14) begin
      ex_s = 0;
      ey_s++;
      if (ey_s == 7) ey_s = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    rst_s = 1'b1;
    #1;
    rst   = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_pixelx", 32'(vd.pixelx), 799);
    chk("rst_pixely", 32'(vd.pixely), 524);
    chk("rst_de",     32'(vd.de), 0);
    chk("rst_hsync",  32'(vd.hsync), 1);
    chk("rst_vsync",  32'(vd.vsync), 1);
    chk("rst_line_start",  32'(vd.line_start), 0);
    chk("rst_frame_start", 32'(vd.frame_start), 0);
    chk("s_rst_pixelx", 32'(vs.pixelx), 13);
    chk("s_rst_pixely", 32'(vs.pixely), 6);

    // Release and run the first full line.
    rst = 1'b1;
    ex = 0; ey = 0;
    hs_low = 0; de_hi = 0; ls_cnt = 0;
    @(negedge clk);
    repeat (800) step_d();
    chk("line_hsync_low_clks", hs_low, 96);
    chk("line_de_clks",        de_hi, 640);
    chk("line_start_pulses",   ls_cnt, 1);

    // Line wrap (799,10) -> (0,11).
    while (!(ex == 799 && ey == 10)) step_d();
    step_d();
    chk("wrap_pixelx", 32'(vd.pixelx), 0);
    chk("wrap_pixely", 32'(vd.pixely), 11);

    // Asynchronous reset between edges at (300,12).
    while (!(ex == 300 && ey == 12)) step_d();
    chk("pre_rst_pixelx", 32'(vd.pixelx), 300);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pixelx", 32'(vd.pixelx), 799);
    chk("async_rst_pixely", 32'(vd.pixely), 524);
    chk("async_rst_de",     32'(vd.de), 0);
    chk("async_rst_hsync",  32'(vd.hsync), 1);
    chk("async_rst_vsync",  32'(vd.vsync), 1);
    chk("async_rst_line_start", 32'(vd.line_start), 0);
    @(negedge clk);
    @(negedge clk);
    chk("held_rst_pixelx", 32'(vd.pixelx), 799);
    rst = 1'b1;
    ex = 0; ey = 0;
    @(negedge clk);
    repeat (30) step_d();

    // Small raster: two full frames of 98 clks each.
    rst_s = 1'b1;
    ex_s = 0; ey_s = 0;
    s_hs_low = 0; s_vs_low = 0; s_de_hi = 0; s_ls_cnt = 0; s_fs_cnt = 0; s_corner = 0;
    @(negedge clk);
    repeat (98) step_s();
    chk("s_frame_hsync_low", s_hs_low, 14);
    chk("s_frame_vsync_low", s_vs_low, 14);
    chk("s_frame_de_clks",   s_de_hi, 32);
    chk("s_frame_line_starts", s_ls_cnt, 7);
    chk("s_frame_starts",    s_fs_cnt, 1);
    chk("s_last_active_seen", s_corner, 1);
    repeat (98) step_s();
    chk("s_two_frame_starts", s_fs_cnt, 2);
    chk("s_two_last_active",  s_corner, 2);
    chk("s_end_pixelx", 32'(vs.pixelx), 0);
    chk("s_end_pixely", 32'(vs.pixely), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
